// File: rtl/regbank_nb.sv
// Register bank with per-register RW / write-1-to-clear / read-only behaviour,
// byte-strobed writes and a registered read port with a one-cycle valid pulse.
module regbank_nb #(
    parameter int              DW       = 32,
    parameter int              AW       = 3,
    parameter int              NREG     = 8,
    parameter logic [NREG-1:0] W1C_MASK = '0,
    parameter logic [NREG-1:0] RO_MASK  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [DW/8-1:0]    wstrb_i,
    input  logic               clr_i,
    input  logic               ren_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [DW-1:0]      rdata_o,
    output logic               rvalid_o,
    input  logic [NREG*DW-1:0] hw_set_i,
    input  logic [NREG*DW-1:0] hw_ro_i,
    output logic [NREG*DW-1:0] regs_o,
    output logic               irq_o
);
    localparam int NB = DW / 8;

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [DW-1:0]           rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [DW-1:0]           byte_mask;

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < NB; k++) byte_mask[k*8 +: 8] = {8{wstrb_i[k]}};
    end

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        logic          wr_hit;
        logic [DW-1:0] set_v, ro_v, nxt;

        assign wr_hit = wen_i && (waddr_i == AW'(i));
        assign set_v  = hw_set_i[i*DW +: DW];
        assign ro_v   = hw_ro_i[i*DW +: DW];
        assign regs_d[i] = nxt;

        if (RO_MASK[i]) begin : g_ro
            logic unused_in;
            assign unused_in = ^{wr_hit, set_v};
            always_comb nxt = clr_i ? '0 : ro_v;
        end else if (W1C_MASK[i]) begin : g_w1c
            logic unused_in;
            assign unused_in = ^ro_v;
            // Hardware set is applied after the clear so a same-cycle event is never lost.
            always_comb begin
                nxt = regs_q[i];
                if (wr_hit) nxt = nxt & ~(wdata_i & byte_mask);
                nxt = nxt | set_v;
                if (clr_i) nxt = '0;
            end
        end else begin : g_rw
            logic unused_in;
            assign unused_in = ^{set_v, ro_v};
            always_comb begin
                nxt = regs_q[i];
                if (wr_hit) nxt = (regs_q[i] & ~byte_mask) | (wdata_i & byte_mask);
                if (clr_i) nxt = '0;
            end
        end
    end

    // Reads sample the current state, so a colliding write is seen only by later reads.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = ren_i;
        if (ren_i) begin
            for (int i = 0; i < NREG; i++) begin
                if (raddr_i == AW'(i)) rdata_d = regs_q[i];
            end
        end
    end

    always_comb begin
        irq_o = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (W1C_MASK[i] && !RO_MASK[i]) irq_o = irq_o | (|regs_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign regs_o   = regs_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule

// File: doc/regbank_nb.md
REGBANK_NB -- requirements
Module: regbank_nb

Interface
REQ-001 SHALL have parameter DW, default 32: register width in bits; multiple of 8.
REQ-002 SHALL have parameter AW, default 3: address width.
REQ-003 SHALL have parameter NREG, default 8: implemented registers; 1 <= NREG <= 2**AW.
REQ-004 SHALL have parameter W1C_MASK, NREG bits, default 0: bit i=1 makes register i write-1-to-clear status.
REQ-005 SHALL have parameter RO_MASK, NREG bits, default 0: bit i=1 makes register i read-only; RO_MASK wins over W1C_MASK.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port wen_i, input, 1: write enable.
REQ-009 SHALL have port waddr_i, input, AW: write address.
REQ-010 SHALL have port wdata_i, input, DW: write data.
REQ-011 SHALL have port wstrb_i, input, DW/8: byte write strobes.
REQ-012 SHALL have port clr_i, input, 1: synchronous clear of all registers.
REQ-013 SHALL have port ren_i, input, 1: read request.
REQ-014 SHALL have port raddr_i, input, AW: read address.
REQ-015 SHALL have port rdata_o, output, DW: registered read data.
REQ-016 SHALL have port rvalid_o, output, 1: rdata_o valid, one-cycle pulse.
REQ-017 SHALL have port hw_set_i, input, NREG*DW: per-bit set for W1C registers; register i at bits [i*DW +: DW].
REQ-018 SHALL have port hw_ro_i, input, NREG*DW: load value for RO registers, same packing.
REQ-019 SHALL have port regs_o, output, NREG*DW: current contents of all registers, same packing.
REQ-020 SHALL have port irq_o, output, 1: OR of all bits of all W1C registers.

Function
REQ-021 RW register i SHALL, when wen_i=1 and waddr_i=i, load wdata_i byte k only where wstrb_i[k]=1; other bytes hold.
REQ-022 W1C register i SHALL clear bit b when written with wdata_i[b]=1 in a strobed byte; bits written 0 or unstrobed hold.
REQ-023 W1C register SHALL set bit b when hw_set_i bit is 1; same-cycle set and write-1-clear of one bit SHALL leave bit = 1.
REQ-024 RO register i SHALL load hw_ro_i slice every cycle; writes to it SHALL have no effect.
REQ-025 clr_i=1 SHALL zero all registers next edge, overriding writes, hw_set_i and hw_ro_i that cycle.
REQ-026 Writes with waddr_i >= NREG SHALL be ignored without side effect.
REQ-027 ren_i=1 SHALL produce rvalid_o=1 and rdata_o=register[raddr_i] exactly one cycle later; rvalid_o SHALL be 1 only in that cycle.
REQ-028 When rvalid_o=0, rdata_o SHALL be 0.
REQ-029 A read of raddr_i >= NREG SHALL return rvalid_o=1, rdata_o=0.
REQ-030 A read and write to the same address in the same cycle SHALL return the pre-write value.
REQ-031 Back-to-back reads SHALL be accepted every cycle at full throughput.
REQ-032 irq_o and regs_o SHALL reflect register state combinationally, with no extra latency.

Reset
REQ-033 On rst_n=0, all registers, rdata_o and rvalid_o SHALL go to 0 asynchronously; irq_o SHALL be 0.
REQ-034 A read issued in the cycle before reset asserts SHALL NOT produce rvalid_o after reset release.

Verification
Parameters for all scenarios: DW=32, AW=2, NREG=3, W1C_MASK=3'b010, RO_MASK=3'b100.
REQ-035 Byte-strobe write: write reg0 0xAABBCCDD with strb 4'b1111, then 0x11223344 with strb 4'b0101, then read reg0 -> rdata 0xAA22CC44, rvalid for 1 cycle.
REQ-036 W1C: hw_set reg1 0x0000_0081, then write reg1 0x1 -> reg1=0x80 and irq_o=1; write 0x80 -> reg1=0 and irq_o=0; set and clear bit0 in the same cycle -> bit0=1.
REQ-037 RO and out-of-range: hw_ro=0x5A5A5A5A, write reg2 0xFFFFFFFF -> read 0x5A5A5A5A; read addr 3 -> rvalid=1, rdata=0; write addr 3 -> regs_o unchanged.
REQ-038 Collision and throughput: write reg0 0x12345678 and read reg0 in the same cycle while reg0=0 -> rdata 0; reads on 3 consecutive cycles -> 3 consecutive rvalid pulses.
REQ-039 Clear/reset: clr_i together with a write to reg0 -> all registers 0; assert rst_n mid-read -> rvalid_o=0 and all outputs 0 after release.
